rr_pkt_arbiter: RTL and testbench

Round-robin, packet-locking arbiter that shares one valid/ready pipeline stage among NUM_REQ requesters. Each requester presents a valid/ready/data stream with a last-beat marker. The block grants one requester at a time, holds the grant for a whole packet, and drives a registered output stage with source identification. It sits in front of the shared pipeline register chain and decides which upstream source owns it.

---
 rtl/rr_pkt_arbiter.sv | 90 +++++++++
 tb/tb_rr_pkt_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_pkt_arbiter.sv
// rtl/rr_pkt_arbiter.sv - round-robin packet-locking arbiter with registered output stage
module rr_pkt_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int bus_width = 8,
   parameter int SRC_W     = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*bus_width-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [bus_width-1:0]           out_data,
   output logic                           out_last,
   output logic [SRC_W-1:0]               out_src
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOCK = 1'b1;

   logic [0:0]            state;
   logic [SRC_W-1:0]      ptr;
   logic [SRC_W-1:0]      owner;
   logic [SRC_W-1:0]      winner;
   logic [SRC_W-1:0]      cand_idx;
   logic                  has_winner;
   logic [NUM_REQ-1:0]    grant;
   logic                  load;
   logic                  xfer;
   logic [bus_width-1:0]  win_data;
   int                    cand;

   // In IDLE, search upward from ptr+1 so the last winner has lowest priority.
   always_comb begin
      winner     = owner;
      has_winner = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      if (state == S_LOCK) begin
         has_winner = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = SRC_W'(cand);
            if (!has_winner && req_valid[cand_idx]) begin
               winner     = cand_idx;
               has_winner = 1'b1;
            end
         end
      end
      grant = '0;
      if (has_winner) grant[winner] = 1'b1;
   end

   assign load      = !out_valid || out_ready;
   assign req_ready = (load && !rst) ? grant : '0;
   assign xfer      = load && !rst && has_winner && req_valid[winner];
   assign win_data  = req_data[int'(winner)*bus_width +: bus_width];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= SRC_W'(NUM_REQ - 1);
         owner     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_last  <= req_last[winner];
         out_src   <= winner;
         if (state == S_IDLE) begin
            ptr <= winner;
            if (!req_last[winner]) begin
               state <= S_LOCK;
               owner <= winner;
            end
         end else if (req_last[winner]) begin
            state <= S_IDLE;
         end
      end else if (load) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// tb/tb_rr_pkt_arbiter.sv - scoreboard bench for rr_pkt_arbiter
module tb_rr_pkt_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_src;

   int n_tests = 0;
   int n_fail  = 0;

   // One stimulus row per cycle: e is the required req_ready, z demands out_valid == 0.
   typedef struct packed {
      logic        r;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        o;
      logic [3:0]  e;
      logic        z;
   } row_t;

   logic [10:0] sb[$];

   always #5 clk = ~clk;

   rr_pkt_arbiter #(.NUM_REQ(4), .bus_width(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_src(out_src)
   );

   function automatic row_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] d, input logic o, input logic [3:0] e,
                               input logic z);
      row_t t;
      t = '{r, v, l, d, o, e, z};
      return t;
   endfunction

   task automatic test_reset;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'hF, 4'hF, 32'h13121110, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h1, 0));
      rows.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h2, 0));
      rows.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h4, 0));
      rows.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h8, 0));
      rows.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h1, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL reset_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (c.z) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_out_valid row %0d: got %b expected 0", i, out_valid);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL reset_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL reset_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL reset_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_packet_lock;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'b0010, 4'b0010, 32'h33221100, 1, 4'b0010, 0));
      rows.push_back(mk(0, 4'b1111, 4'b1011, 32'h33A01100, 1, 4'b0100, 0));
      rows.push_back(mk(0, 4'b1111, 4'b1011, 32'h33A11100, 1, 4'b0100, 0));
      rows.push_back(mk(0, 4'b1111, 4'b1111, 32'h33A21100, 1, 4'b0100, 0));
      rows.push_back(mk(0, 4'b1111, 4'b1111, 32'h33A21100, 1, 4'b1000, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL lock_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL lock_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL lock_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL lock_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_owner_gap;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B00F, 1, 4'b0010, 0));
      rows.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000B00F, 1, 4'b0010, 0));
      rows.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000B00F, 1, 4'b0010, 1));
      rows.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000B00F, 1, 4'b0010, 1));
      rows.push_back(mk(0, 4'b0011, 4'b0011, 32'h0000B10F, 1, 4'b0010, 0));
      rows.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000B10F, 1, 4'b0001, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL gap_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (c.z) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_out_valid row %0d: got %b expected 0", i, out_valid);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL gap_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL gap_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL gap_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_backpressure;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'b0001, 4'b0001, 32'h00006655, 1, 4'b0001, 0));
      repeat (4) rows.push_back(mk(0, 4'b0010, 4'b0010, 32'h00006655, 0, 4'b0000, 0));
      rows.push_back(mk(0, 4'b0010, 4'b0010, 32'h00006655, 1, 4'b0010, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL bp_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (i >= 3 && i <= 6) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h55) begin
               n_fail++;
               $display("FAIL bp_hold row %0d: got valid %b data %h expected valid 1 data 55", i, out_valid, out_data);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL bp_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL bp_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_wrap_fairness;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'b1010, 4'b1010, 32'h30001000, 1, 4'b0010, 0));
      for (int j = 1; j <= 5; j++)
         rows.push_back(mk(0, 4'b1000, 4'b1000, {8'h30 + 8'(j), 24'h0}, 1, 4'b1000, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL wrap_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL wrap_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL wrap_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset_mid_packet;
      row_t rows[$];
      row_t c;
      logic [10:0] exp;
      logic [3:0] acc;
      int s;
      repeat (2) rows.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 1));
      rows.push_back(mk(0, 4'b0101, 4'b0000, 32'h00E000C0, 1, 4'b0001, 0));
      rows.push_back(mk(1, 4'b0101, 4'b0000, 32'h00E000C1, 1, 4'b0000, 0));
      rows.push_back(mk(0, 4'b0101, 4'b0000, 32'h00E000C0, 1, 4'b0001, 1));
      rows.push_back(mk(0, 4'b0101, 4'b0001, 32'h00E000C1, 1, 4'b0001, 0));
      rows.push_back(mk(0, 4'b0100, 4'b0100, 32'h00E000C1, 1, 4'b0100, 0));
      repeat (2) rows.push_back(mk(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0));
      for (int i = 0; i < rows.size(); i++) begin
         c = rows[i];
         rst = c.r; req_valid = c.v; req_last = c.l; req_data = c.d; out_ready = c.o;
         @(negedge clk);
         n_tests++;
         if (req_ready !== c.e) begin
            n_fail++;
            $display("FAIL rstmid_ready row %0d: got %b expected %b", i, req_ready, c.e);
         end
         if (c.z) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL rstmid_out_valid row %0d: got %b expected 0", i, out_valid);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rstmid_extra_beat row %0d: got src %0d data %h expected none", i, out_src, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_src, out_last, out_data} !== exp) begin
                  n_fail++;
                  $display("FAIL rstmid_beat row %0d: got %h expected %h", i, {out_src, out_last, out_data}, exp);
               end
            end
         end
         acc = c.e & c.v;
         if (acc != 0) begin
            for (int k = 0; k < 4; k++) if (acc[k]) s = k;
            sb.push_back({2'(s), c.l[s], c.d[s*8 +: 8]});
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_drain: got %0d pending beats expected 0", sb.size());
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_packet_lock();
      test_owner_gap();
      test_backpressure();
      test_wrap_fairness();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
